// File: rtl/vector_packer_if.sv
// Sample-in / vector-out bus of the vector packer. The packer connects to the
// slave modport; the producer/consumer side connects to the master modport.
interface vector_packer_if #(
  parameter int NUM_INPUTS = 16,
  parameter int DWIDTH     = 8
);
  localparam int FILL_W = $clog2(NUM_INPUTS);

  logic [DWIDTH-1:0]            i_dat;
  logic                         i_dat_valid;
  logic                         i_flush;
  logic [NUM_INPUTS*DWIDTH-1:0] o_dat_vector;
  logic                         o_dat_valid;
  logic [FILL_W-1:0]            o_fill;
  logic [15:0]                  o_vec_cnt;

  modport master (
    output i_dat, i_dat_valid, i_flush,
    input  o_dat_vector, o_dat_valid, o_fill, o_vec_cnt
  );

  modport slave (
    input  i_dat, i_dat_valid, i_flush,
    output o_dat_vector, o_dat_valid, o_fill, o_vec_cnt
  );
endinterface

// File: rtl/vector_packer.sv
// Serial-to-parallel packer: collects NUM_INPUTS samples into one vector for
// the adder tree, with flush-driven early emission of zero-padded partials.
module vector_packer #(
  parameter int NUM_INPUTS = 16,
  parameter int DWIDTH     = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  vector_packer_if.slave  bus
);
  localparam int FILL_W = $clog2(NUM_INPUTS);
  localparam int VEC_W  = NUM_INPUTS * DWIDTH;
  localparam logic [FILL_W-1:0] LAST_SLOT = FILL_W'(NUM_INPUTS - 1);

  typedef enum logic {
    ST_FILL,
    ST_EMIT
  } state_e;

  state_e            state_q, state_d;
  logic [VEC_W-1:0]  buf_q, buf_d;
  logic [VEC_W-1:0]  vec_q, vec_d;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic [15:0]       cnt_q, cnt_d;

  logic [VEC_W-1:0]  merged;
  logic              full_emit;
  logic              flush_emit;
  logic              emit;

  always_comb begin
    // NOTE: every variable gets a default before any branch, so no latch can be inferred.
    merged = buf_q;
    if (bus.i_dat_valid) begin
      merged[int'(fill_q)*DWIDTH +: DWIDTH] = bus.i_dat;
    end

    full_emit  = bus.i_dat_valid && (fill_q == LAST_SLOT);
    flush_emit = bus.i_flush && ((fill_q != '0) || bus.i_dat_valid);
    emit       = full_emit || flush_emit;

    buf_d   = buf_q;
    vec_d   = vec_q;
    fill_d  = fill_q;
    cnt_d   = cnt_q;
    state_d = ST_FILL;

    if (emit) begin
      // The emitting edge also clears the buffer, so the next sample lands in slot 0.
      vec_d   = merged;
      buf_d   = '0;
      fill_d  = '0;
      cnt_d   = cnt_q + 16'd1;
      state_d = ST_EMIT;
    end else if (bus.i_dat_valid) begin
      buf_d  = merged;
      fill_d = fill_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: the collect buffer is reset too, because flushed partials expose unwritten slots as zero.
      state_q <= ST_FILL;
      buf_q   <= '0;
      vec_q   <= '0;
      fill_q  <= '0;
      cnt_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments here so all registers update from the same pre-edge values.
      state_q <= state_d;
      buf_q   <= buf_d;
      vec_q   <= vec_d;
      fill_q  <= fill_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.o_dat_vector = vec_q;
  assign bus.o_dat_valid  = (state_q == ST_EMIT);
  assign bus.o_fill       = fill_q;
  assign bus.o_vec_cnt    = cnt_q;
endmodule

// File: tb/tb_vector_packer.sv
// Self-checking bench for vector_packer: directed scenarios plus random
// valid/flush/reset traffic against a queue-based reference model.
module tb_vector_packer;
  localparam int NI    = 4;
  localparam int DW    = 8;
  localparam int VW    = NI * DW;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  vector_packer_if #(.NUM_INPUTS(NI), .DWIDTH(DW)) bus ();

  vector_packer #(.NUM_INPUTS(NI), .DWIDTH(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: samples waiting to be emitted, plus expected outputs.
  byte unsigned pend[$];
  logic [VW-1:0] m_vec   = '0;
  logic          m_valid = 1'b0;
  int unsigned   m_cnt   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [VW-1:0] pack_pending();
    logic [VW-1:0] v;
    v = '0;
    foreach (pend[k]) v = v | (VW'(pend[k]) << (k * DW));
    return v;
  endfunction

  // One clock cycle: drive on the falling edge, advance the model at the
  // rising edge, then compare every output just after it.
  task automatic step(input bit rst, input bit v, input byte unsigned d, input bit f);
    @(negedge clk);
    rst_n           = ~rst;
    bus.i_dat_valid = v;
    bus.i_dat       = d;
    bus.i_flush     = f;
    @(posedge clk);
    if (rst) begin
      pend.delete();
      m_vec   = '0;
      m_valid = 1'b0;
      m_cnt   = 0;
    end else begin
      if (v) pend.push_back(d);
      if (pend.size() == NI || (f && pend.size() > 0)) begin
        m_vec   = pack_pending();
        m_valid = 1'b1;
        m_cnt   = (m_cnt + 1) % 65536;
        pend.delete();
      end else begin
        m_valid = 1'b0;
      end
    end
    #1;
    check("valid",   64'(bus.o_dat_valid),  64'(m_valid));
    check("fill",    64'(bus.o_fill),       64'(pend.size()));
    check("vector",  64'(bus.o_dat_vector), 64'(m_vec));
    check("vec_cnt", 64'(bus.o_vec_cnt),    64'(m_cnt));
  endtask

  task automatic send(input byte unsigned d);
    step(1'b0, 1'b1, d, 1'b0);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 8'h00, 1'b0);
  endtask

  initial begin
    bus.i_dat_valid = 1'b1;
    bus.i_dat       = 8'hEE;
    bus.i_flush     = 1'b0;

    // Reset with valid asserted: samples must be ignored.
    step(1'b1, 1'b1, 8'hEE, 1'b0);
    step(1'b1, 1'b1, 8'hEF, 1'b1);
    check("rst_vector", 64'(bus.o_dat_vector), 64'h0);
    check("rst_fill",   64'(bus.o_fill),       64'h0);

    // Basic full vector.
    send(8'h01); send(8'h02); send(8'h03);
    check("t1_no_strobe_yet", 64'(bus.o_dat_valid), 64'h0);
    send(8'h04);
    check("t1_strobe",  64'(bus.o_dat_valid),  64'h1);
    check("t1_vector",  64'(bus.o_dat_vector), 64'h04030201);
    check("t1_cnt",     64'(bus.o_vec_cnt),    64'h1);
    idle();
    check("t1_hold",    64'(bus.o_dat_vector), 64'h04030201);

    // Continuous line rate: strobes four cycles apart.
    for (int i = 0; i < 8; i++) begin
      send(8'(8'h10 + i));
      if (i == 3) check("t2_vec_a", 64'(bus.o_dat_vector), 64'h13121110);
      if (i == 7) check("t2_vec_b", 64'(bus.o_dat_vector), 64'h17161514);
    end
    idle();

    // Flush of a partial, then a flush with nothing held.
    send(8'hAA); send(8'hBB);
    step(1'b0, 1'b0, 8'h00, 1'b1);
    check("t3_vector", 64'(bus.o_dat_vector), 64'h0000BBAA);
    check("t3_fill",   64'(bus.o_fill),       64'h0);
    step(1'b0, 1'b0, 8'h00, 1'b1);
    check("t3_empty_flush", 64'(bus.o_dat_valid), 64'h0);

    // Flush together with the completing sample: one emission only.
    send(8'h11); send(8'h22); send(8'h33);
    step(1'b0, 1'b1, 8'h44, 1'b1);
    check("t4_vector", 64'(bus.o_dat_vector), 64'h44332211);
    idle();

    // Reset mid-fill discards the partial.
    send(8'h55); send(8'h66); send(8'h77);
    step(1'b1, 1'b0, 8'h00, 1'b0);
    check("t5_rst_cnt", 64'(bus.o_vec_cnt), 64'h0);
    send(8'h01); send(8'h02); send(8'h03); send(8'h04);
    check("t5_vector", 64'(bus.o_dat_vector), 64'h04030201);
    check("t5_cnt",    64'(bus.o_vec_cnt),    64'h1);

    // Gapped valid.
    send(8'h01); idle(); idle(); send(8'h02); send(8'h03); idle(); send(8'h04);
    check("t6_vector", 64'(bus.o_dat_vector), 64'h04030201);
    idle(); idle();

    // Random traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      step($urandom_range(0, 199) == 0,
           $urandom_range(0, 99) < 70,
           8'($urandom),
           $urandom_range(0, 99) < 12);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
